// File: rtl/sample_decimator.sv
// Sample decimator: reduces a signed sample stream by R = 2^log2_ratio, emitting the
// first sample (pick), the floor average, or the min/max pair (peak) of each window.
module sample_decimator #(
    parameter int WIDTH      = 12,
    parameter int MAX_LOG2_R = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [3:0]              log2_ratio,
    input  logic                    x_valid,
    input  logic signed [WIDTH-1:0] x,
    input  logic                    y_ready,
    output logic                    y_valid,
    output logic signed [WIDTH-1:0] y_lo,
    output logic signed [WIDTH-1:0] y_hi,
    output logic                    overflow
);

    localparam int SW = WIDTH + MAX_LOG2_R;
    localparam int CW = MAX_LOG2_R + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  r_state, w_state_next;
    logic [1:0]              r_mode;
    logic [3:0]              r_log2;
    logic [CW-1:0]           r_cnt;
    logic signed [SW-1:0]    r_sum;
    logic signed [WIDTH-1:0] r_min, r_max, r_first;
    logic                    r_y_valid, r_overflow;
    logic signed [WIDTH-1:0] r_y_lo, r_y_hi;

    logic                    w_start, w_stop, w_accept, w_first, w_close;
    logic [CW-1:0]           w_last_idx;
    logic signed [SW-1:0]    w_x_ext, w_sum_next, w_avg_full;
    logic signed [WIDTH-1:0] w_min_next, w_max_next, w_pick, w_avg;
    logic signed [WIDTH-1:0] w_res_lo, w_res_hi;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)  w_state_next = RUN;
            RUN:     if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_start    = (r_state == IDLE) && enable;
    assign w_stop     = (r_state == RUN) && !enable;
    assign w_accept   = (r_state == RUN) && x_valid;
    assign w_first    = (r_cnt == '0);
    assign w_last_idx = (CW'(1) << r_log2) - CW'(1);
    assign w_close    = w_accept && (r_cnt == w_last_idx);

    // Window statistics including the sample accepted this cycle, so a closing
    // window's result can be registered on the same edge.
    assign w_x_ext    = {{MAX_LOG2_R{x[WIDTH-1]}}, x};
    assign w_sum_next = w_first ? w_x_ext : r_sum + w_x_ext;
    assign w_min_next = (w_first || x < r_min) ? x : r_min;
    assign w_max_next = (w_first || x > r_max) ? x : r_max;
    assign w_pick     = w_first ? x : r_first;
    assign w_avg_full = w_sum_next >>> r_log2;
    assign w_avg      = w_avg_full[WIDTH-1:0];

    always_comb begin
        w_res_lo = w_pick;
        w_res_hi = w_pick;
        case (r_mode)
            2'd1: begin
                w_res_lo = w_avg;
                w_res_hi = w_avg;
            end
            2'd2: begin
                w_res_lo = w_min_next;
                w_res_hi = w_max_next;
            end
            default: ;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mode     <= '0;
            r_log2     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_mode     <= mode;
                r_log2     <= (int'(log2_ratio) > MAX_LOG2_R) ? 4'(MAX_LOG2_R) : log2_ratio;
                r_overflow <= 1'b0;
            end else if (w_close && r_y_valid && !y_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE || w_stop) begin
            r_cnt   <= '0;
            r_sum   <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_first <= '0;
        end else if (w_accept) begin
            r_cnt   <= w_close ? '0 : r_cnt + CW'(1);
            r_sum   <= w_sum_next;
            r_min   <= w_min_next;
            r_max   <= w_max_next;
            r_first <= w_pick;
        end
    end

    // A pending result is only replaced when it is consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_valid <= 1'b0;
            r_y_lo    <= '0;
            r_y_hi    <= '0;
        end else if (w_close && (!r_y_valid || y_ready)) begin
            r_y_valid <= 1'b1;
            r_y_lo    <= w_res_lo;
            r_y_hi    <= w_res_hi;
        end else if (r_y_valid && y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign y_valid  = r_y_valid;
    assign y_lo     = r_y_lo;
    assign y_hi     = r_y_hi;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator: a per-cycle vector table for the three modes
// plus hand sequences for backpressure, abort, clamp and reset.
module tb_sample_decimator;

    localparam int WIDTH      = 12;
    localparam int MAX_LOG2_R = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [1:0]              mode;
    logic [3:0]              log2_ratio;
    logic                    x_valid;
    logic signed [WIDTH-1:0] x;
    logic                    y_ready;
    logic                    y_valid;
    logic signed [WIDTH-1:0] y_lo, y_hi;
    logic                    overflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic [1:0] md;
        logic [3:0] l2;
        logic       xv;
        int         xs;
        logic       yr;
        logic       ev;
        int         elo;
        int         ehi;
        logic       eov;
    } vec_t;

    vec_t vecs[$];

    sample_decimator #(.WIDTH(WIDTH), .MAX_LOG2_R(MAX_LOG2_R)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .log2_ratio(log2_ratio),
        .x_valid   (x_valid),
        .x         (x),
        .y_ready   (y_ready),
        .y_valid   (y_valid),
        .y_lo      (y_lo),
        .y_hi      (y_hi),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic en, input logic [1:0] md, input logic [3:0] l2,
                                input logic xv, input int xs, input logic yr,
                                input logic ev, input int elo, input int ehi, input logic eov);
        vec_t v;
        v.en = en; v.md = md; v.l2 = l2; v.xv = xv; v.xs = xs; v.yr = yr;
        v.ev = ev; v.elo = elo; v.ehi = ehi; v.eov = eov;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic drive(input logic en, input logic [1:0] md, input logic [3:0] l2,
                         input logic xv, input int xs, input logic yr);
        enable     = en;
        mode       = md;
        log2_ratio = l2;
        x_valid    = xv;
        x          = WIDTH'(xs);
        y_ready    = yr;
        @(posedge clk);
        #1;
    endtask

    // y_lo/y_hi are only meaningful while y_valid is expected high.
    task automatic check(input string name, input logic ev, input int elo, input int ehi,
                         input logic eov);
        logic bad;
        n_cmp++;
        bad = (y_valid !== ev) || (overflow !== eov) ||
              (ev && ((y_lo !== WIDTH'(elo)) || (y_hi !== WIDTH'(ehi))));
        if (bad) begin
            n_err++;
            $display("FAIL %s: got v=%0b lo=%0d hi=%0d ov=%0b, want v=%0b lo=%0d hi=%0d ov=%0b",
                     name, y_valid, y_lo, y_hi, overflow, ev, elo, ehi, eov);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = '0; log2_ratio = '0;
        x_valid = 1'b0; x = '0; y_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (y_valid !== 1'b0 || y_lo !== '0 || y_hi !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%0b lo=%0d hi=%0d ov=%0b, want all zero",
                     y_valid, y_lo, y_hi, overflow);
        end
        rst = 1'b0;

        // Pick, R=4; mode/ratio inputs change mid-run and must be ignored.
        add(1, 0, 2, 0,  0, 1,  0,  0,  0, 0);
        add(1, 0, 2, 1, 10, 1,  0,  0,  0, 0);
        add(1, 0, 2, 1, 11, 1,  0,  0,  0, 0);
        add(1, 0, 2, 1, 12, 1,  0,  0,  0, 0);
        add(1, 0, 2, 1, 13, 1,  1, 10, 10, 0);
        add(1, 1, 0, 1, 14, 1,  0,  0,  0, 0);
        add(1, 1, 0, 1, 15, 1,  0,  0,  0, 0);
        add(1, 1, 0, 1, 16, 1,  0,  0,  0, 0);
        add(1, 1, 0, 1, 17, 1,  1, 14, 14, 0);
        add(0, 0, 0, 0,  0, 1,  0,  0,  0, 0);
        // Average, R=4: floor(-9/4) = -3, then 18/4 -> 4.
        add(1, 1, 2, 0,  0, 1,  0,  0,  0, 0);
        add(1, 1, 2, 1, -3, 1,  0,  0,  0, 0);
        add(1, 1, 2, 1, -2, 1,  0,  0,  0, 0);
        add(1, 1, 2, 1, -2, 1,  0,  0,  0, 0);
        add(1, 1, 2, 1, -2, 1,  1, -3, -3, 0);
        add(1, 1, 2, 1,  4, 1,  0,  0,  0, 0);
        add(1, 1, 2, 1,  4, 1,  0,  0,  0, 0);
        add(1, 1, 2, 1,  5, 1,  0,  0,  0, 0);
        add(1, 1, 2, 1,  5, 1,  1,  4,  4, 0);
        add(0, 0, 0, 0,  0, 1,  0,  0,  0, 0);
        // Peak, R=8, with an invalid-cycle value that must not count.
        add(1, 2, 3, 0,     0, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1,     5, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1,    -7, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1,   100, 1,  0,     0,    0, 0);
        add(1, 2, 3, 0,  2000, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1,     0, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1, -2048, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1,  2047, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1,     3, 1,  0,     0,    0, 0);
        add(1, 2, 3, 1,     1, 1,  1, -2048, 2047, 0);
        add(0, 0, 0, 0,     0, 1,  0,     0,    0, 0);
        // Mode 3 behaves as pick, R=2.
        add(1, 3, 1, 0,  0, 1,  0,  0,  0, 0);
        add(1, 3, 1, 1,  7, 1,  0,  0,  0, 0);
        add(1, 3, 1, 1,  9, 1,  1,  7,  7, 0);
        add(0, 0, 0, 0,  0, 1,  0,  0,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].md, vecs[i].l2, vecs[i].xv, vecs[i].xs, vecs[i].yr);
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].elo, vecs[i].ehi, vecs[i].eov);
        end

        // Backpressure with R=1.
        drive(1, 0, 0, 0, 0, 0); check("bp_start",   0, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 0); check("bp_first",   1, 1, 1, 0);
        drive(1, 0, 0, 1, 2, 0); check("bp_drop",    1, 1, 1, 1);
        drive(1, 0, 0, 1, 3, 1); check("bp_reload",  1, 3, 3, 1);
        drive(1, 0, 0, 0, 0, 1); check("bp_drain",   0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1); check("bp_sticky",  0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1); check("bp_ovf_clr", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);

        // Abort a partial window; the restarted window must not include old samples.
        drive(1, 1, 2, 0,   0, 1);
        drive(1, 1, 2, 1, 100, 1);
        drive(1, 1, 2, 1, 100, 1);
        drive(0, 1, 2, 0,   0, 1); check("abort_idle", 0, 0, 0, 0);
        drive(1, 1, 2, 0,   0, 1);
        drive(1, 1, 2, 1,   8, 1); check("abort_s1", 0, 0, 0, 0);
        drive(1, 1, 2, 1,   8, 1); check("abort_s2", 0, 0, 0, 0);
        drive(1, 1, 2, 1,   8, 1); check("abort_s3", 0, 0, 0, 0);
        drive(1, 1, 2, 1,   8, 1); check("abort_res", 1, 8, 8, 0);
        drive(0, 1, 2, 0,   0, 1); check("abort_ack", 0, 0, 0, 0);

        // Clamp: log2_ratio=15 must act as R=256.
        drive(1, 0, 15, 0, 0, 0);
        for (int i = 0; i < 255; i++) drive(1, 0, 15, 1, (i % 100) + 1, 0);
        check("clamp_no_early", 0, 0, 0, 0);
        drive(1, 0, 15, 1, 50, 0); check("clamp_close", 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 15, 1, 9, 0);
        check("clamp_hold", 1, 1, 1, 0);

        // Reset mid-window with a pending result.
        rst = 1'b1;
        drive(1, 2, 3, 1, 77, 0);
        n_cmp++;
        if (y_valid !== 1'b0 || y_lo !== '0 || y_hi !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got v=%0b lo=%0d hi=%0d ov=%0b, want all zero",
                     y_valid, y_lo, y_hi, overflow);
        end
        rst = 1'b0;
        drive(1, 1, 1, 0, 0, 1); check("post_rst_start", 0, 0, 0, 0);
        drive(1, 1, 1, 1, 6, 1); check("post_rst_s1",    0, 0, 0, 0);
        drive(1, 1, 1, 1, 8, 1); check("post_rst_avg",   1, 7, 7, 0);
        drive(0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_decimator.md
SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

Interface
REQ-001 SHALL have parameter WIDTH, default 12: sample width in bits, input and output, signed.
REQ-002 SHALL have parameter MAX_LOG2_R, default 8: largest supported log2 of the decimation ratio.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port enable, input, 1: run when high, idle when low.
REQ-006 SHALL have port mode, input, 2: 0 = pick, 1 = average, 2 = peak; 3 is treated as pick.
REQ-007 SHALL have port log2_ratio, input, 4: decimation ratio R = 2^log2_ratio.
REQ-008 SHALL have port x_valid, input, 1: x carries a sample this cycle.
REQ-009 SHALL have port x, input, WIDTH, signed: input sample (filtered stream from the FIR stage).
REQ-010 SHALL have port y_ready, input, 1: the consumer accepts the output this cycle.
REQ-011 SHALL have port y_valid, output, 1: y_lo/y_hi hold a result.
REQ-012 SHALL have port y_lo, output, WIDTH, signed: result, or window minimum in peak mode.
REQ-013 SHALL have port y_hi, output, WIDTH, signed: result, or window maximum in peak mode.
REQ-014 SHALL have port overflow, output, 1: sticky flag, a result was dropped.

Function
REQ-015 SHALL implement states IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-016 SHALL latch mode and log2_ratio on the IDLE->RUN transition; changes during RUN are ignored.
REQ-017 SHALL clamp a latched log2_ratio greater than MAX_LOG2_R to MAX_LOG2_R.
REQ-018 SHALL, on entering IDLE, discard any partial window: clear the sample counter and accumulators.
REQ-019 SHALL leave a pending output untouched on entering IDLE.
REQ-020 SHALL accept a sample only when state=RUN and x_valid=1; x is ignored at all other times.
REQ-021 SHALL count accepted samples 0..R-1 and close the window on the R-th sample, the counter wrapping to 0.
REQ-022 SHALL, in pick mode, output the first sample of each window on both y_lo and y_hi.
REQ-023 SHALL, in average mode, sum the R samples into a signed accumulator of width WIDTH+MAX_LOG2_R without overflow.
REQ-024 SHALL form the average result as an arithmetic right shift of the sum by log2_ratio (floor), placed on both y_lo and y_hi.
REQ-025 SHALL, in peak mode, place the signed minimum of the window on y_lo and the signed maximum on y_hi.
REQ-026 SHALL present a closed window's result with y_valid=1 on the cycle after its last sample is accepted (latency 1).
REQ-027 SHALL, when R=1, pass every accepted sample unchanged with latency 1.
REQ-028 SHALL hold y_valid, y_lo and y_hi stable until a cycle in which y_valid=1 and y_ready=1.
REQ-029 SHALL clear y_valid after that handshake cycle unless a new result loads in the same cycle.
REQ-030 SHALL, when a window closes in the same cycle as a handshake, load the new result with y_valid remaining 1 and overflow unchanged.
REQ-031 SHALL, when a window closes while y_valid=1 and y_ready=0, drop the new result, keep the old one and set overflow.
REQ-032 SHALL keep overflow set until rst or the next IDLE->RUN transition.
REQ-033 SHALL start the next window on the sample immediately following a window close, with no dead cycle.

Reset
REQ-034 SHALL, while rst=1, force state=IDLE, counter=0, accumulators=0, y_valid=0, y_lo=0, y_hi=0, overflow=0 and the latched mode/log2_ratio=0.
REQ-035 SHALL give rst priority over all other inputs, including mid-window and with an output pending (the pending result is lost).

Verification
REQ-036 SHALL cover pick: mode=0, log2_ratio=2, x=10,11,12,13,14,15,16,17 every cycle, y_ready=1 -> y=10 one cycle after 13, y=14 one cycle after 17.
REQ-037 SHALL cover average: mode=1, log2_ratio=2, x=-3,-2,-2,-2 -> sum=-9, y_lo=y_hi=-3 (floor); then x=4,4,5,5 -> 4.
REQ-038 SHALL cover peak: mode=2, log2_ratio=3, x=5,-7,100,0,-2048,2047,3,1 -> y_lo=-2048, y_hi=2047.
REQ-039 SHALL cover backpressure: R=1, y_ready=0, samples 1,2 -> y=1 held, overflow=1; y_ready=1 together with sample 3 -> 3 loads, y_valid stays 1.
REQ-040 SHALL cover abort: log2_ratio=2, after 2 samples drop enable for 1 cycle, re-enable with 4 samples 8,8,8,8 in average mode -> single result 8, overflow=0.
REQ-041 SHALL cover reset and clamp: rst pulse mid-window with y_valid=1 -> all outputs 0 next cycle; log2_ratio=15 latched -> R=256.
